// File: rtl/dsp48e1_mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dsp48e1_mac_sequencer_pkg
// Purpose : shared constants and types for the DSP48E1 dot-product sequencer.
//           Holds the OPMODE codes for "load product" and "accumulate
//           product". It also holds the fixed ALUMODE/INMODE/CARRYINSEL
//           values and the result record that is returned downstream.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package dsp48e1_mac_sequencer_pkg;

  // X=M, Y=M, Z=0  -> P = A*B (starts a new dot product)
  localparam logic [6:0] OPM_M          = 7'b000_0101;
  // X=M, Y=M, Z=P  -> P = P + A*B (continues the running sum)
  localparam logic [6:0] OPM_PM         = 7'b010_0101;

  localparam logic [3:0] ALUMODE_ADD    = 4'b0000;
  localparam logic [4:0] INMODE_A2B2    = 5'b00000;
  localparam logic [2:0] CARRYINSEL_CIN = 3'b000;

  // Default term-counter width used by the result record.
  localparam int RES_LEN_W = 8;

  typedef struct packed {
    logic [47:0]          data;
    logic [RES_LEN_W-1:0] len;
  } result_t;

  // OPMODE for an accepted beat: the first term of a vector clears Z.
  function automatic logic [6:0] beat_opmode(input logic first);
    return first ? OPM_M : OPM_PM;
  endfunction

endpackage

// File: rtl/dsp48e1_mac_sequencer_mac_result_fifo.sv
// ---------------------------------------------------------------------------
// mac_result_fifo
// Purpose : small first-word-fall-through FIFO that holds finished dot
//           products until the result consumer takes them.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           push, push_data write one entry (ignored when full)
//           pop             remove head entry (ignored when empty)
//           head_data       current head entry (0 after reset)
//           empty           no entries held
//           count           number of entries held
// ---------------------------------------------------------------------------
module mac_result_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 56,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // One register per entry; each entry only loads when the write pointer
  // selects it. Entries are cleared so the head reads 0 out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/dsp48e1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp48e1_mac_sequencer
// Purpose : control stage in front of one DSP48E1 slice (AREG=BREG=2,
//           MREG=1, PREG=1, OPMODEREG=1, CEs high) that computes signed dot
//           products. Operand beats are registered onto A/B. A per-beat
//           OPMODE is delayed so it meets the slice's M register. A
//           last-of-vector tag follows the slice latency so P is captured
//           exactly when the final sum lands.
// Ports   : CLK, RST_N           clock, asynchronous active-low reset
//           s_valid/s_ready      operand stream handshake
//           s_a, s_b, s_last     25b/18b signed operands, end-of-vector mark
//           A, B, OPMODE         slice data and opcode drive
//           ALUMODE, INMODE,
//           CARRYINSEL, CARRYIN  slice controls, held constant
//           P                    slice result
//           m_valid/m_ready      result stream handshake
//           m_data, m_len        dot product (mod 2^48), saturating term count
// ---------------------------------------------------------------------------
module dsp48e1_mac_sequencer
  import dsp48e1_mac_sequencer_pkg::*;
#(
  parameter int AREG      = 2,
  parameter int MREG      = 1,
  parameter int PREG      = 1,
  parameter int OPMODEREG = 1,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [24:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic [29:0]      A,
  output logic [17:0]      B,
  output logic [6:0]       OPMODE,
  output logic [3:0]       ALUMODE,
  output logic [4:0]       INMODE,
  output logic [2:0]       CARRYINSEL,
  output logic             CARRYIN,
  input  logic [47:0]      P,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic [CNT_W-1:0] m_len
);

  // Delay from the A/B drive register to the slice's OPMODE register input,
  // and from the drive register to the cycle in which P holds the result.
  localparam int OP_DLY  = AREG + MREG - OPMODEREG;
  localparam int RES_DLY = AREG + MREG + PREG;
  localparam int FW      = 48 + CNT_W;
  localparam int FCW     = $clog2(OUT_DEPTH + 1);
  // Wide enough for every tag stage plus every FIFO entry.
  localparam int CW      = $clog2(RES_DLY + OUT_DEPTH + 2) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------
  // Input handshake and per-vector bookkeeping
  // ---------------------------------------------------------------------
  logic             s_ready_reg;
  logic             accept;
  logic             first_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign accept = s_valid && s_ready_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      if (first_reg)              cnt_next = CNT_W'(1);
      else if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_reg <= 1'b1;
      cnt_reg   <= '0;
    end else if (accept) begin
      first_reg <= s_last;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Drive stage: operands, opcode and result tag for this beat.
  // A cycle with no accept launches a zero product that accumulates
  // harmlessly, so the slice never needs to stall.
  // ---------------------------------------------------------------------
  logic [29:0]      a_reg;
  logic [17:0]      b_reg;
  logic [6:0]       op0_reg;
  logic             tag0_last_reg;
  logic [CNT_W-1:0] tag0_len_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg         <= '0;
      b_reg         <= '0;
      op0_reg       <= OPM_M;
      tag0_last_reg <= 1'b0;
      tag0_len_reg  <= '0;
    end else begin
      a_reg         <= accept ? {{5{s_a[24]}}, s_a} : 30'd0;
      b_reg         <= accept ? s_b : 18'd0;
      op0_reg       <= accept ? beat_opmode(first_reg) : OPM_PM;
      tag0_last_reg <= accept && s_last;
      tag0_len_reg  <= accept ? cnt_next : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Opcode and result-tag delay lines (stage 0 is the drive register)
  // ---------------------------------------------------------------------
  logic [6:0]       op_q       [OP_DLY+1];
  logic             tag_last_q [RES_DLY+1];
  logic [CNT_W-1:0] tag_len_q  [RES_DLY+1];

  assign op_q[0]       = op0_reg;
  assign tag_last_q[0] = tag0_last_reg;
  assign tag_len_q[0]  = tag0_len_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= OP_DLY; gi++) begin : g_op
      logic [6:0] op_reg;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) op_reg <= OPM_M;
        else        op_reg <= op_q[gi-1];
      end
      assign op_q[gi] = op_reg;
    end

    for (gi = 1; gi <= RES_DLY; gi++) begin : g_tag
      logic             last_reg;
      logic [CNT_W-1:0] len_reg;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          last_reg <= 1'b0;
          len_reg  <= '0;
        end else begin
          last_reg <= tag_last_q[gi-1];
          len_reg  <= tag_len_q[gi-1];
        end
      end
      assign tag_last_q[gi] = last_reg;
      assign tag_len_q[gi]  = len_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Result capture: the tag leaving the last stage marks the cycle in
  // which P holds the completed sum.
  // ---------------------------------------------------------------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [FW-1:0]    fifo_head;

  assign fifo_push = tag_last_q[RES_DLY];
  assign fifo_pop  = m_valid && m_ready;

  mac_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (fifo_push),
    .push_data ({P, tag_len_q[RES_DLY]}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Credit: every accepted last beat owns a FIFO slot from acceptance until
  // it is popped. A tag moving from the delay line into the FIFO leaves the
  // total unchanged, so only new tags and pops alter it. The registered
  // ready is computed from the post-edge total so it never over-commits.
  // ---------------------------------------------------------------------
  logic [CW-1:0] inflight;
  logic [CW-1:0] outstanding_next;
  logic          s_ready_next;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RES_DLY; i++) begin
      inflight = inflight + CW'(tag_last_q[i]);
    end
    outstanding_next = inflight + CW'(fifo_count)
                     + CW'(accept && s_last) - CW'(fifo_pop);
    s_ready_next     = (outstanding_next < CW'(OUT_DEPTH));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) s_ready_reg <= 1'b0;
    else        s_ready_reg <= s_ready_next;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign s_ready    = s_ready_reg;
  assign A          = a_reg;
  assign B          = b_reg;
  assign OPMODE     = op_q[OP_DLY];
  assign ALUMODE    = ALUMODE_ADD;
  assign INMODE     = INMODE_A2B2;
  assign CARRYINSEL = CARRYINSEL_CIN;
  assign CARRYIN    = 1'b0;
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_head[FW-1:CNT_W];
  assign m_len      = fifo_head[CNT_W-1:0];

endmodule

// File: tb/tb_dsp48e1_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsp48e1_mac_sequencer
// Directed bench for the DSP48E1 dot-product sequencer. It includes a
// behavioural model of the attached slice (A/B two registers deep, M and
// OPMODE one, P one) so that results come back through the real latency.
// ---------------------------------------------------------------------------
module tb_dsp48e1_mac_sequencer;
  import dsp48e1_mac_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [24:0] s_a = '0;
  logic [17:0] s_b = '0;
  logic        s_last = 1'b0;
  logic [29:0] A;
  logic [17:0] B;
  logic [6:0]  OPMODE;
  logic [3:0]  ALUMODE;
  logic [4:0]  INMODE;
  logic [2:0]  CARRYINSEL;
  logic        CARRYIN;
  logic [47:0] P;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [47:0] m_data;
  logic [7:0]  m_len;

  dsp48e1_mac_sequencer dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .A          (A),
    .B          (B),
    .OPMODE     (OPMODE),
    .ALUMODE    (ALUMODE),
    .INMODE     (INMODE),
    .CARRYINSEL (CARRYINSEL),
    .CARRYIN    (CARRYIN),
    .P          (P),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_len      (m_len)
  );

  always #5 clk = ~clk;

  // Slice model (not reset, like the real slice in this system).
  logic [29:0] a1 = '0, a2 = '0;
  logic [17:0] b1 = '0, b2 = '0;
  logic [47:0] m_r = '0, p_r = '0;
  logic [6:0]  opm_r = '0;
  always @(posedge clk) begin
    a1    <= A;
    a2    <= a1;
    b1    <= B;
    b2    <= b1;
    m_r   <= {{18{a2[29]}}, a2} * {{30{b2[17]}}, b2};
    opm_r <= OPMODE;
    p_r   <= (opm_r == 7'b000_0101) ? m_r : p_r + m_r;
  end
  assign P = p_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: records every popped result and the cycle it was seen.
  logic [47:0] got_data[$];
  logic [7:0]  got_len[$];
  int          got_cyc[$];
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_len.push_back(m_len);
      got_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Offer one beat and wait (bounded) for it to be accepted.
  task automatic send(input int a, input int b, input logic last, output int acc);
    int n;
    s_valid = 1'b1;
    s_a     = a[24:0];
    s_b     = b[17:0];
    s_last  = last;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
    acc     = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_a     = '0;
    s_b     = '0;
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (got_data.size() < n && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("result_count", 64'(got_data.size()), 64'(n));
  endtask

  task automatic expect_res(input string tag, input logic [47:0] d, input logic [7:0] l);
    if (got_data.size() > 0) begin
      check({tag, "_data"}, {16'd0, got_data.pop_front()}, {16'd0, d});
      check({tag, "_len"}, {56'd0, got_len.pop_front()}, {56'd0, l});
      void'(got_cyc.pop_front());
    end else begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_A", {34'd0, A}, 64'd0);
    check("rst_B", {46'd0, B}, 64'd0);
    check("rst_OPMODE", {57'd0, OPMODE}, 64'h05);
    check("rst_m_data", {16'd0, m_data}, 64'd0);
    check("rst_m_len", {56'd0, m_len}, 64'd0);
    check("const_ctrl", {52'd0, ALUMODE, INMODE, CARRYINSEL}, 64'd0);
    check("const_cin", {63'd0, CARRYIN}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {63'd0, s_ready}, 64'd1);

    // T1: (2,3),(-4,5),(7,-1) -> -21, latency 5
    send(2, 3, 1'b0, t0);
    send(-4, 5, 1'b0, t1);
    send(7, -1, 1'b1, t2);
    wait_results(1);
    if (got_cyc.size() > 0) check("t1_latency", 64'(got_cyc[0] - t2), 64'd5);
    expect_res("t1", 48'hFFFF_FFFF_FFEB, 8'd3);

    // T2: length-1 extremes
    send(-16777216, -131072, 1'b1, t0);
    wait_results(1);
    expect_res("t2", 48'h0200_0000_0000, 8'd1);

    // T3: back-to-back vectors
    send(1, 1, 1'b0, t0);
    send(1, 1, 1'b1, t1);
    send(3, 4, 1'b1, t2);
    check("t3_no_bubble", 64'(t2 - t0), 64'd2);
    wait_results(2);
    expect_res("t3a", 48'd2, 8'd2);
    expect_res("t3b", 48'd12, 8'd1);

    // T4: back-pressure via credit
    m_ready = 1'b0;
    send(1, 2, 1'b1, t0);
    send(3, 4, 1'b1, t1);
    check("t4_consecutive", 64'(t1 - t0), 64'd1);
    check("t4_ready_low", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b1; s_a = 25'd5; s_b = 18'd6; s_last = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t4_ready_held", {63'd0, s_ready}, 64'd0);
    check("t4_head_valid", {63'd0, m_valid}, 64'd1);
    check("t4_head_data", {16'd0, m_data}, 64'd2);
    check("t4_none_popped", 64'(got_data.size()), 64'd0);
    m_ready = 1'b1;
    send(5, 6, 1'b1, t3);
    wait_results(3);
    expect_res("t4a", 48'd2, 8'd1);
    expect_res("t4b", 48'd12, 8'd1);
    expect_res("t4c", 48'd30, 8'd1);

    // T5: idle cycles inside a vector
    send(5, 5, 1'b0, t0);
    repeat (3) begin @(posedge clk); #1; end
    send(2, 2, 1'b1, t1);
    wait_results(1);
    expect_res("t5", 48'd29, 8'd2);

    // T6: reset mid-vector
    send(9, 9, 1'b0, t0);
    send(8, 8, 1'b0, t1);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("t6_rst_ready", {63'd0, s_ready}, 64'd0);
    rst_n = 1'b1;
    send(6, 7, 1'b1, t2);
    wait_results(1);
    repeat (20) begin @(posedge clk); #1; end
    check("t6_only_one", 64'(got_data.size()), 64'd1);
    expect_res("t6", 48'd42, 8'd1);

    // T7: term counter saturation (300 zero terms + one 1*1 term)
    for (int i = 0; i < 300; i++) send(0, 0, 1'b0, t0);
    send(1, 1, 1'b1, t1);
    wait_results(1);
    expect_res("t7_sat", 48'd1, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp48e1_mac_sequencer.md
Name: dsp48e1_mac_sequencer

Overview:
- Upstream control stage that feeds one DSP48E1 slice (AREG=2, BREG=2, MREG=1, PREG=1, OPMODEREG=1, all CEs tied high) to compute signed dot products.
- Accepts a valid/ready stream of operand pairs with a last-of-vector marker, drives A/B/OPMODE/ALUMODE/INMODE/CARRYINSEL, and tracks the slice pipeline with tag shift registers.
- Captures P when a vector's final accumulation lands and returns it on a valid/ready result stream through a small output FIFO.

Parameters:
AREG, 2, A/B input pipeline depth of the attached slice
MREG, 1, multiplier register depth of the slice
PREG, 1, P register depth of the slice
OPMODEREG, 1, OPMODE register depth of the slice
OUT_DEPTH, 2, result FIFO entries (power of 2, >=1)
CNT_W, 8, width of per-vector term counter

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
s_valid  in  1  operand beat valid
s_ready  out  1  operand beat accepted when s_valid&s_ready
s_a  in  25  signed multiplicand
s_b  in  18  signed multiplier
s_last  in  1  beat is final term of vector
A  out  30  to slice A port
B  out  18  to slice B port
OPMODE  out  7  to slice OPMODE
ALUMODE  out  4  to slice ALUMODE (constant 4'b0000)
INMODE  out  5  to slice INMODE (constant 5'b00000)
CARRYINSEL  out  3  to slice CARRYINSEL (constant 3'b000)
CARRYIN  out  1  constant 0
P  in  48  slice P output
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  48  dot-product result (two's complement, wraps mod 2^48)
m_len  out  CNT_W  terms in vector, saturating

Behaviour:
- Reset (RST_N=0, async): A=0, B=0, OPMODE=7'b000_0101, s_ready=0, m_valid=0, m_data=0, m_len=0; tag pipes, FIFO, counters and first-flag cleared; first-flag reset to 1 after release. s_ready may rise on the first edge after deassertion.
- Registered drive: on accept, next cycle A={{5{s_a[24]}},s_a}, B=s_b; no accept -> A=0, B=0 (bubble, product 0).
- first-flag: set after reset and after accepting an s_last beat; cleared by accepting any non-last beat.
- OPMODE: per-beat code carried through an OP_DLY = AREG+MREG-OPMODEREG (=2) cycle shift register behind the A/B drive, so the slice's registered OPMODE coincides with the M register output. Code is 7'b000_0101 (P=M) for a first beat, 7'b010_0101 (P=P+M) for any other beat or bubble. Bubbles therefore preserve the accumulator; idle between vectors is harmless.
- Result tag: accepted s_last enters an RES_DLY = AREG+MREG+PREG (=4) cycle shift register with the term count. When the tag emerges, P is valid and is pushed into the FIFO with m_len. Latency: last beat accepted at edge t -> P captured at edge t+5 -> m_valid at t+5 if FIFO was empty.
- Term counter: increments per accepted beat, saturates at 2^CNT_W-1, reloads to 1 on a first beat. Count including the last beat travels with the tag.
- Credit flow control: inflight = number of last-tags in the RES shift register. s_ready = (inflight + fifo_count) < OUT_DEPTH, registered. The slice pipeline never stalls and no result is ever dropped.
- FIFO: m_valid = !empty; m_data/m_len show head. Pop on m_valid&m_ready. Simultaneous push and pop keeps the count unchanged; push into a full FIFO is impossible by credit.
- Back-to-back vectors (last then first on consecutive cycles) are fully supported; a length-1 vector (first&last) yields P = a*b.
- Reset mid-vector: all in-flight work is discarded. Stale P in the slice is harmless because the next vector starts with Z=0.

Decomposition:
- Shared package: OPMODE constants OPM_M (7'b000_0101) and OPM_PM (7'b010_0101), ALUMODE_ADD, INMODE_A2B2, CARRYINSEL_CIN, and a result_t struct {data[47:0], len[CNT_W-1:0]}.
- One sub-module: mac_result_fifo (parameterised depth, async active-low reset, count output).

Test Plan:
- Vector (2,3),(-4,5),(7,-1) with last on 3rd, m_ready=1 -> m_data=48'hFFFF_FFFF_FFEB (-21), m_len=3, m_valid exactly 5 cycles after last accept.
- Length-1 vector s_a=-16777216, s_b=-131072 -> m_data=48'h0200_0000_0000, m_len=1.
- Two back-to-back vectors (1,1),(1,1)last then (3,4)last -> results 2 then 12, in order, no bubble between accepts.
- m_ready=0, three length-1 vectors offered -> s_ready low after 2 accepted; raising m_ready drains 2 results and the 3rd vector proceeds.
- Vector (5,5),[3 idle cycles],(2,2)last -> m_data=29; the bubbles do not disturb the accumulator.
- RST_N pulsed low mid-vector, then (6,7)last -> only result 42 appears, m_len=1, no stale output.
